// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
//
// Shares one single-port synchronous RAM between the fetch port (if_*) and
// the load/store port (d_*). At most one access is granted per cycle. The
// grant and the RAM command are combinational in the request cycle. The
// response appears one cycle later, when the RAM read data is valid.
//
// Data accesses are converted from byte address + size into a word address,
// byte enables and lane-replicated write data. Load data is aligned and
// sign- or zero-extended. A misaligned access, or an access with an illegal
// size, is still granted and still gets a response with err = 1, but the RAM
// is never enabled for it.
//
// Configuration macro:
//    MEM_ARB_RR_EN  when defined, simultaneous requests are arbitrated
//                   round-robin: the port not granted last time wins.
//                   When undefined, the data port always wins a tie.
//
// Ports:
//    clk, rst                    clock, asynchronous active-high reset
//    if_req_valid/ready, if_addr fetch request (byte address)
//    if_rsp_valid, if_rdata, if_err   fetch response
//    d_req_valid/ready, d_addr, d_we, d_size, d_unsigned, d_wdata
//                                load/store request
//    d_rsp_valid, d_rdata, d_err load data / store ack
//    ram_en, ram_we, ram_be, ram_addr, ram_wdata, ram_rdata   RAM macro
// -----------------------------------------------------------------------------
module mem_port_arbiter #(
   parameter int RAM_AW = 10
) (
   input  logic              clk,
   input  logic              rst,
   // fetch port
   input  logic              if_req_valid,
   output logic              if_req_ready,
   input  logic [31:0]       if_addr,
   output logic              if_rsp_valid,
   output logic [31:0]       if_rdata,
   output logic              if_err,
   // load/store port
   input  logic              d_req_valid,
   output logic              d_req_ready,
   input  logic [31:0]       d_addr,
   input  logic              d_we,
   input  logic [1:0]        d_size,
   input  logic              d_unsigned,
   input  logic [31:0]       d_wdata,
   output logic              d_rsp_valid,
   output logic [31:0]       d_rdata,
   output logic              d_err,
   // RAM macro
   output logic              ram_en,
   output logic              ram_we,
   output logic [3:0]        ram_be,
   output logic [RAM_AW-1:0] ram_addr,
   output logic [31:0]       ram_wdata,
   input  logic [31:0]       ram_rdata
);

   // The state names which port owns the response in the next cycle.
   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_IF_RSP = 2'd1;
   localparam logic [1:0] ST_D_RSP  = 2'd2;

   // ram_size_e encoding
   localparam logic [1:0] SZ_BYTE = 2'd0;
   localparam logic [1:0] SZ_HALF = 2'd1;
   localparam logic [1:0] SZ_WORD = 2'd2;

   logic       grant_if;
   logic       grant_d;
   logic       if_misal;
   logic       d_misal;

   logic [1:0] state_q,    state_d;
   logic       if_err_q,   if_err_d;
   logic       d_err_q,    d_err_d;
   logic [1:0] d_off_q,    d_off_d;
   logic [1:0] d_size_q,   d_size_d;
   logic       d_uns_q,    d_uns_d;
   logic       d_we_q,     d_we_d;

   // Address bits above the RAM word address are ignored, so accesses wrap.
   logic       unused_addr_bits;
   assign unused_addr_bits = ^{if_addr[31:RAM_AW+2], d_addr[31:RAM_AW+2]};

   // --------------------------------------------------------------------------
   // Arbitration
   // --------------------------------------------------------------------------
`ifdef MEM_ARB_RR_EN
   // 1 = data port was granted most recently. It resets to "fetch", so the
   // first tie after reset goes to data.
   logic last_d_q, last_d_d;

   always_comb begin
      last_d_d = last_d_q;
      if (grant_d)
         last_d_d = 1'b1;
      else if (grant_if)
         last_d_d = 1'b0;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         last_d_q <= 1'b0;
      else
         last_d_q <= last_d_d;
   end
`endif

   always_comb begin
      grant_if = 1'b0;
      grant_d  = 1'b0;
      if (!rst) begin
         if (if_req_valid && d_req_valid) begin
`ifdef MEM_ARB_RR_EN
            if (last_d_q)
               grant_if = 1'b1;
            else
               grant_d  = 1'b1;
`else
            grant_d = 1'b1;
`endif
         end else begin
            grant_if = if_req_valid;
            grant_d  = d_req_valid;
         end
      end
   end

   assign if_req_ready = grant_if;
   assign d_req_ready  = grant_d;

   // --------------------------------------------------------------------------
   // Alignment checks
   // --------------------------------------------------------------------------
   assign if_misal = |if_addr[1:0];

   always_comb begin
      case (d_size)
         SZ_BYTE: d_misal = 1'b0;
         SZ_HALF: d_misal = d_addr[0];
         SZ_WORD: d_misal = |d_addr[1:0];
         default: d_misal = 1'b1;   // 2'b11 is not a legal size
      endcase
   end

   // --------------------------------------------------------------------------
   // RAM command
   // --------------------------------------------------------------------------
   always_comb begin
      ram_en    = 1'b0;
      ram_we    = 1'b0;
      ram_be    = 4'b0000;
      ram_addr  = d_addr[RAM_AW+1:2];
      ram_wdata = d_wdata;
      if (grant_if) begin
         ram_addr = if_addr[RAM_AW+1:2];
         if (!if_misal) begin
            ram_en = 1'b1;
            ram_be = 4'b1111;
         end
      end else if (grant_d) begin
         ram_addr = d_addr[RAM_AW+1:2];
         if (!d_misal) begin
            ram_en = 1'b1;
            if (d_we) begin
               ram_we = 1'b1;
               // Replicate narrow data across lanes so the byte enables alone
               // select where it lands.
               case (d_size)
                  SZ_BYTE: begin
                     ram_be    = 4'b0001 << d_addr[1:0];
                     ram_wdata = {4{d_wdata[7:0]}};
                  end
                  SZ_HALF: begin
                     ram_be    = 4'b0011 << d_addr[1:0];
                     ram_wdata = {2{d_wdata[15:0]}};
                  end
                  default: begin
                     ram_be    = 4'b1111;
                     ram_wdata = d_wdata;
                  end
               endcase
            end else begin
               ram_be = 4'b1111;
            end
         end
      end
   end

   // --------------------------------------------------------------------------
   // Response state
   // --------------------------------------------------------------------------
   always_comb begin
      if (grant_d)
         state_d = ST_D_RSP;
      else if (grant_if)
         state_d = ST_IF_RSP;
      else
         state_d = ST_IDLE;

      if_err_d = grant_if & if_misal;
      d_err_d  = grant_d & d_misal;

      // Data request attributes are captured only on acceptance.
      d_off_d  = d_off_q;
      d_size_d = d_size_q;
      d_uns_d  = d_uns_q;
      d_we_d   = d_we_q;
      if (grant_d) begin
         d_off_d  = d_addr[1:0];
         d_size_d = d_size;
         d_uns_d  = d_unsigned;
         d_we_d   = d_we;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         if_err_q <= 1'b0;
         d_err_q  <= 1'b0;
         d_off_q  <= 2'b00;
         d_size_q <= SZ_BYTE;
         d_uns_q  <= 1'b0;
         d_we_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         if_err_q <= if_err_d;
         d_err_q  <= d_err_d;
         d_off_q  <= d_off_d;
         d_size_q <= d_size_d;
         d_uns_q  <= d_uns_d;
         d_we_q   <= d_we_d;
      end
   end

   // --------------------------------------------------------------------------
   // Response outputs
   // --------------------------------------------------------------------------
   logic [31:0] load_shift;
   logic [31:0] load_ext;

   assign load_shift = ram_rdata >> {d_off_q, 3'b000};

   always_comb begin
      case (d_size_q)
         SZ_BYTE: load_ext = {{24{load_shift[7]  & ~d_uns_q}}, load_shift[7:0]};
         SZ_HALF: load_ext = {{16{load_shift[15] & ~d_uns_q}}, load_shift[15:0]};
         default: load_ext = load_shift;
      endcase
   end

   assign if_rsp_valid = (state_q == ST_IF_RSP);
   assign if_err       = if_rsp_valid & if_err_q;
   assign if_rdata     = (if_rsp_valid && !if_err_q) ? ram_rdata : 32'h0;

   assign d_rsp_valid  = (state_q == ST_D_RSP);
   assign d_err        = d_rsp_valid & d_err_q;
   // Stores and errored accesses return zero data.
   assign d_rdata      = (d_rsp_valid && !d_err_q && !d_we_q) ? load_ext : 32'h0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_port_arbiter
//
// Directed test for mem_port_arbiter with a behavioural RAM model. Each step
// drives one cycle of requests and checks the combinational grant and RAM
// command. It also pushes the expected response onto a scoreboard queue. The
// entry is popped and compared after the clock edge.
// -----------------------------------------------------------------------------
module tb_mem_port_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        if_req_valid, if_req_ready, if_rsp_valid, if_err;
   logic [31:0] if_addr, if_rdata;
   logic        d_req_valid, d_req_ready, d_we, d_unsigned, d_rsp_valid, d_err;
   logic [1:0]  d_size;
   logic [31:0] d_addr, d_wdata, d_rdata;
   logic        ram_en, ram_we;
   logic [3:0]  ram_be;
   logic [9:0]  ram_addr;
   logic [31:0] ram_wdata, ram_rdata;

   int n_cmp = 0;
   int n_err = 0;

   typedef struct {
      bit        iv;
      bit [31:0] ird;
      bit        ie;
      bit        dv;
      bit [31:0] drd;
      bit        de;
   } exp_t;

   exp_t sb[$];

   mem_port_arbiter #(.RAM_AW(10)) dut (
      .clk(clk), .rst(rst),
      .if_req_valid(if_req_valid), .if_req_ready(if_req_ready), .if_addr(if_addr),
      .if_rsp_valid(if_rsp_valid), .if_rdata(if_rdata), .if_err(if_err),
      .d_req_valid(d_req_valid), .d_req_ready(d_req_ready), .d_addr(d_addr),
      .d_we(d_we), .d_size(d_size), .d_unsigned(d_unsigned), .d_wdata(d_wdata),
      .d_rsp_valid(d_rsp_valid), .d_rdata(d_rdata), .d_err(d_err),
      .ram_en(ram_en), .ram_we(ram_we), .ram_be(ram_be), .ram_addr(ram_addr),
      .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
   );

   always #5 clk = ~clk;

   // Behavioural single-port RAM with a registered read.
   logic [31:0] mem [0:1023];
   always @(posedge clk) begin
      if (ram_en) begin
         if (ram_we) begin
            for (int b = 0; b < 4; b++)
               if (ram_be[b]) mem[ram_addr][8*b +: 8] <= ram_wdata[8*b +: 8];
         end
         ram_rdata <= mem[ram_addr];
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
      end
   endtask

   function automatic exp_t mk(input bit iv, input bit [31:0] ird, input bit ie,
                               input bit dv, input bit [31:0] drd, input bit de);
      exp_t e;
      e.iv = iv; e.ird = ird; e.ie = ie; e.dv = dv; e.drd = drd; e.de = de;
      return e;
   endfunction

   task automatic check_rsp(input string tag);
      exp_t e;
      if (sb.size() == 0) begin
         chk({tag, " sb_empty"}, 32'd1, 32'd0);
         return;
      end
      e = sb.pop_front();
      chk({tag, " if_rsp_valid"}, 32'(if_rsp_valid), 32'(e.iv));
      chk({tag, " if_rdata"},     if_rdata,           e.ird);
      chk({tag, " if_err"},       32'(if_err),        32'(e.ie));
      chk({tag, " d_rsp_valid"},  32'(d_rsp_valid),   32'(e.dv));
      chk({tag, " d_rdata"},      d_rdata,            e.drd);
      chk({tag, " d_err"},        32'(d_err),         32'(e.de));
   endtask

   // One request cycle: drive, check grant/RAM command, push expected
   // response, clock, then pop and compare.
   task automatic req(input string tag,
                      input bit iv, input bit [31:0] ia,
                      input bit dv, input bit [31:0] da, input bit we,
                      input bit [1:0] sz, input bit un, input bit [31:0] wd,
                      input bit gi, input bit gd,
                      input bit ren, input bit rwe, input bit [3:0] be,
                      input bit [9:0] raddr, input bit [31:0] rwd,
                      input exp_t e);
      @(negedge clk);
      if_req_valid = iv; if_addr = ia;
      d_req_valid = dv; d_addr = da; d_we = we; d_size = sz;
      d_unsigned = un; d_wdata = wd;
      #1;
      chk({tag, " if_req_ready"}, 32'(if_req_ready), 32'(gi));
      chk({tag, " d_req_ready"},  32'(d_req_ready),  32'(gd));
      chk({tag, " ram_en"},       32'(ram_en),       32'(ren));
      chk({tag, " ram_we"},       32'(ram_we),       32'(rwe));
      chk({tag, " ram_be"},       32'(ram_be),       32'(be));
      if (ren) chk({tag, " ram_addr"}, 32'(ram_addr), 32'(raddr));
      if (rwe) chk({tag, " ram_wdata"}, ram_wdata, rwd);
      sb.push_back(e);
      @(posedge clk);
      #1;
      check_rsp(tag);
      $display("txn %-14s gi=%0d gd=%0d ram_en=%0d be=%b | if_v=%0d if_rd=%08h if_e=%0d d_v=%0d d_rd=%08h d_e=%0d",
               tag, if_req_ready, d_req_ready, ram_en, ram_be,
               if_rsp_valid, if_rdata, if_err, d_rsp_valid, d_rdata, d_err);
   endtask

   bit tie_gd;

   initial begin
      for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
      mem[4] = 32'h0050_0093;
      mem[1] = 32'h8001_1234;
      ram_rdata = 32'h0;

      rst = 1'b1;
      if_req_valid = 0; if_addr = 0;
      d_req_valid = 0; d_addr = 0; d_we = 0; d_size = 0; d_unsigned = 0; d_wdata = 0;
      repeat (2) @(posedge clk);
      #1;
      chk("reset if_rsp_valid", 32'(if_rsp_valid), 32'd0);
      chk("reset d_rsp_valid",  32'(d_rsp_valid),  32'd0);
      chk("reset if_rdata",     if_rdata,          32'h0);
      chk("reset d_rdata",      d_rdata,           32'h0);
      chk("reset if_err",       32'(if_err),       32'd0);
      chk("reset d_err",        32'(d_err),        32'd0);
      @(negedge clk);
      rst = 1'b0;

      //   tag             iv ia        dv da        we sz un wd          gi gd ren rwe be      raddr  rwd
      req("fetch_0x10",    1, 32'h10,   0, 32'h0,    0, 2, 0, 32'h0,      1, 0, 1, 0, 4'hF,  10'd4, 32'h0,
          mk(1, 32'h0050_0093, 0, 0, 32'h0, 0));
      req("lh_s_0x6",      0, 32'h0,    1, 32'h6,    0, 1, 0, 32'h0,      0, 1, 1, 0, 4'hF,  10'd1, 32'h0,
          mk(0, 32'h0, 0, 1, 32'hFFFF_8001, 0));
      req("lhu_0x6",       0, 32'h0,    1, 32'h6,    0, 1, 1, 32'h0,      0, 1, 1, 0, 4'hF,  10'd1, 32'h0,
          mk(0, 32'h0, 0, 1, 32'h0000_8001, 0));
      req("lw_mis_0x2",    0, 32'h0,    1, 32'h2,    0, 2, 0, 32'h0,      0, 1, 0, 0, 4'h0,  10'd0, 32'h0,
          mk(0, 32'h0, 0, 1, 32'h0, 1));
      req("size3_0x0",     0, 32'h0,    1, 32'h0,    0, 3, 0, 32'h0,      0, 1, 0, 0, 4'h0,  10'd0, 32'h0,
          mk(0, 32'h0, 0, 1, 32'h0, 1));
      req("fetch_mis",     1, 32'h12,   0, 32'h0,    0, 2, 0, 32'h0,      1, 0, 0, 0, 4'h0,  10'd0, 32'h0,
          mk(1, 32'h0, 1, 0, 32'h0, 0));
      req("sb_0x7",        0, 32'h0,    1, 32'h7,    1, 0, 0, 32'h1234_56AB, 0, 1, 1, 1, 4'b1000, 10'd1, 32'hABAB_ABAB,
          mk(0, 32'h0, 0, 1, 32'h0, 0));
      req("lb_s_0x7",      0, 32'h0,    1, 32'h7,    0, 0, 0, 32'h0,      0, 1, 1, 0, 4'hF,  10'd1, 32'h0,
          mk(0, 32'h0, 0, 1, 32'hFFFF_FFAB, 0));
      req("sh_0xA",        0, 32'h0,    1, 32'hA,    1, 1, 0, 32'hDEAD_BEEF, 0, 1, 1, 1, 4'b1100, 10'd2, 32'hBEEF_BEEF,
          mk(0, 32'h0, 0, 1, 32'h0, 0));
      req("lh_s_0xA",      0, 32'h0,    1, 32'hA,    0, 1, 0, 32'h0,      0, 1, 1, 0, 4'hF,  10'd2, 32'h0,
          mk(0, 32'h0, 0, 1, 32'hFFFF_BEEF, 0));
      req("sw_0xC",        0, 32'h0,    1, 32'hC,    1, 2, 0, 32'hCAFE_F00D, 0, 1, 1, 1, 4'hF, 10'd3, 32'hCAFE_F00D,
          mk(0, 32'h0, 0, 1, 32'h0, 0));
      req("lbu_0xD",       0, 32'h0,    1, 32'hD,    0, 0, 1, 32'h0,      0, 1, 1, 0, 4'hF,  10'd3, 32'h0,
          mk(0, 32'h0, 0, 1, 32'h0000_00F0, 0));
      req("sh_mis_0x5",    0, 32'h0,    1, 32'h5,    1, 1, 0, 32'h5555_5555, 0, 1, 0, 0, 4'h0, 10'd0, 32'h0,
          mk(0, 32'h0, 0, 1, 32'h0, 1));
      req("idle",          0, 32'h0,    0, 32'h0,    0, 0, 0, 32'h0,      0, 0, 0, 0, 4'h0,  10'd0, 32'h0,
          mk(0, 32'h0, 0, 0, 32'h0, 0));
      req("fetch_wrap",    1, 32'h1010, 0, 32'h0,    0, 2, 0, 32'h0,      1, 0, 1, 0, 4'hF,  10'd4, 32'h0,
          mk(1, 32'h0050_0093, 0, 0, 32'h0, 0));

      // Both ports request for four cycles; the last grant so far was fetch.
      for (int k = 0; k < 4; k++) begin
`ifdef MEM_ARB_RR_EN
         tie_gd = (k % 2 == 0);
`else
         tie_gd = 1'b1;
`endif
         req($sformatf("tie_%0d", k), 1, 32'h10, 1, 32'h10, 0, 2, 0, 32'h0,
             !tie_gd, tie_gd, 1, 0, 4'hF, 10'd4, 32'h0,
             tie_gd ? mk(0, 32'h0, 0, 1, 32'h0050_0093, 0)
                    : mk(1, 32'h0050_0093, 0, 0, 32'h0, 0));
      end

      // Reset in the cycle after a grant drops the pending response.
      @(negedge clk);
      if_req_valid = 1; if_addr = 32'h10;
      d_req_valid = 0;
      @(posedge clk);
      #1;
      rst = 1'b1;
      d_req_valid = 1; d_addr = 32'h10; d_we = 0; d_size = 2;
      #1;
      chk("rst if_rsp_valid", 32'(if_rsp_valid), 32'd0);
      chk("rst if_rdata",     if_rdata,          32'h0);
      chk("rst d_rsp_valid",  32'(d_rsp_valid),  32'd0);
      chk("rst if_req_ready", 32'(if_req_ready), 32'd0);
      chk("rst d_req_ready",  32'(d_req_ready),  32'd0);
      chk("rst ram_en",       32'(ram_en),       32'd0);
      $display("txn %-14s if_v=%0d d_v=%0d ready=%0d/%0d", "rst_mid",
               if_rsp_valid, d_rsp_valid, if_req_ready, d_req_ready);
      if_req_valid = 0; d_req_valid = 0;
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      chk("post_rst if_rsp_valid", 32'(if_rsp_valid), 32'd0);
      chk("post_rst d_rsp_valid",  32'(d_rsp_valid),  32'd0);

      req("post_rst_fetch", 1, 32'h10,  0, 32'h0,    0, 2, 0, 32'h0,      1, 0, 1, 0, 4'hF,  10'd4, 32'h0,
          mk(1, 32'h0050_0093, 0, 0, 32'h0, 0));

      @(negedge clk);
      if_req_valid = 0; d_req_valid = 0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
